// File: rtl/ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | ctrl_pkg                                                             |
// | Shared types and encodings for the multi-cycle RV32I control path.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ctrl_pkg;

  typedef enum logic [2:0] {
    st_fetch     = 3'd0,
    st_decode    = 3'd1,
    st_execute   = 3'd2,
    st_mem       = 3'd3,
    st_writeback = 3'd4,
    st_trap      = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    cls_r       = 4'd0,
    cls_i       = 4'd1,
    cls_load    = 4'd2,
    cls_store   = 4'd3,
    cls_branch  = 4'd4,
    cls_jal     = 4'd5,
    cls_jalr    = 4'd6,
    cls_lui     = 4'd7,
    cls_auipc   = 4'd8,
    cls_illegal = 4'd9
  } iclass_t;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  localparam logic [1:0] c_wb_alu = 2'b00;
  localparam logic [1:0] c_wb_mem = 2'b01;
  localparam logic [1:0] c_wb_pc4 = 2'b10;

  localparam logic [1:0] c_pc_plus4 = 2'b00;
  localparam logic [1:0] c_pc_imm   = 2'b01;
  localparam logic [1:0] c_pc_alu   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/opcode_class.sv
// +----------------------------------------------------------------------+
// | opcode_class                                                         |
// | Combinational map from the 7-bit major opcode to instruction class.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module opcode_class
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls
);

  always_comb begin
    cls = cls_illegal;
    case (opcode)
      c_op_r:      cls = cls_r;
      c_op_i:      cls = cls_i;
      c_op_load:   cls = cls_load;
      c_op_store:  cls = cls_store;
      c_op_branch: cls = cls_branch;
      c_op_jal:    cls = cls_jal;
      c_op_jalr:   cls = cls_jalr;
      c_op_lui:    cls = cls_lui;
      c_op_auipc:  cls = cls_auipc;
      default:     cls = cls_illegal;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// +----------------------------------------------------------------------+
// | multicycle_ctrl                                                      |
// | Fetch/decode/execute/mem/writeback sequencer for the RV32I core.     |
// | Build option: ILLEGAL_TRAP_EN sends illegal opcodes to a sticky TRAP |
// | state; otherwise they retire as NOPs.                                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] instr_in,
  output logic [31:0] ir,
  input  logic        stall,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_done,
  output logic        alu_src_pc,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] retire_cnt,
  output logic        trap,
  output logic [2:0]  state_o
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;
  logic [31:0] r_retire_cnt;
  iclass_t     w_cls;
  logic        w_fetch_accept;

  opcode_class u_opcode_class (
    .opcode (r_ir[6:0]),
    .cls    (w_cls)
  );

  assign w_fetch_accept = (r_state == st_fetch) && imem_ready && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= st_fetch;
      r_ir         <= RESET_IR;
      r_retire_cnt <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_fetch_accept) begin
        r_ir <= instr_in;
      end
      // pc_we is already gated by stall and reset, so it marks exactly one retire
      if (pc_we) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_src_pc = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = c_wb_alu;
    pc_we      = 1'b0;
    pc_sel     = c_pc_plus4;
    if (!reset) begin
      case (r_state)
        st_fetch: begin
          imem_req = 1'b1;
          if (imem_ready) w_next = st_fetch == r_state ? st_decode : r_state;
        end
        st_decode: begin
`ifdef ILLEGAL_TRAP_EN
          w_next = (w_cls == cls_illegal) ? st_trap : st_execute;
`else
          w_next = st_execute;
`endif
        end
        st_execute: begin
          alu_src_pc = (w_cls == cls_auipc) || (w_cls == cls_jal) || (w_cls == cls_branch);
          case (w_cls)
            cls_load, cls_store: w_next = st_mem;
            cls_branch: begin
              pc_we  = 1'b1;
              pc_sel = branch_taken ? c_pc_imm : c_pc_plus4;
              w_next = st_fetch;
            end
            default: w_next = st_writeback;
          endcase
        end
        st_mem: begin
          dmem_req = 1'b1;
          dmem_we  = (w_cls == cls_store);
          if (dmem_done) begin
            if (w_cls == cls_store) begin
              pc_we  = 1'b1;
              pc_sel = c_pc_plus4;
              w_next = st_fetch;
            end else begin
              w_next = st_writeback;
            end
          end
        end
        st_writeback: begin
          // An illegal opcode only gets here as a NOP, so it must not write x[rd]
          rf_we = (r_ir[11:7] != 5'd0) && (w_cls != cls_illegal);
          case (w_cls)
            cls_load:          wb_sel = c_wb_mem;
            cls_jal, cls_jalr: wb_sel = c_wb_pc4;
            default:           wb_sel = c_wb_alu;
          endcase
          pc_we = 1'b1;
          case (w_cls)
            cls_jal:  pc_sel = c_pc_imm;
            cls_jalr: pc_sel = c_pc_alu;
            default:  pc_sel = c_pc_plus4;
          endcase
          w_next = st_fetch;
        end
        st_trap: begin
`ifdef ILLEGAL_TRAP_EN
          w_next = st_trap;
`else
          w_next = st_fetch;
`endif
        end
        default: w_next = st_fetch;
      endcase
      if (stall) begin
        w_next = r_state;
        rf_we  = 1'b0;
        pc_we  = 1'b0;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign trap = !reset && (r_state == st_trap);
`else
  assign trap = 1'b0;
`endif

  assign ir         = r_ir;
  assign retire_cnt = r_retire_cnt;
  assign state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_multicycle_ctrl                                                   |
// | Self-checking bench: per-instruction expected traces built from the  |
// | phase rules, replayed cycle by cycle with random waits and stalls.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam logic [31:0] RST_IR = 32'h0000_0013;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b0;
  logic [31:0] instr_in = 32'd0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        dmem_done = 1'b0;
  wire         imem_req, dmem_req, dmem_we, alu_src_pc, rf_we, pc_we, trap;
  wire  [31:0] ir, retire_cnt;
  wire  [1:0]  wb_sel, pc_sel;
  wire  [2:0]  state_o;

  multicycle_ctrl #(.RESET_IR(RST_IR)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ready(imem_ready),
    .instr_in(instr_in), .ir(ir), .stall(stall), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_done(dmem_done),
    .alu_src_pc(alu_src_pc), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_sel(pc_sel), .retire_cnt(retire_cnt), .trap(trap), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    state_t      st;
    bit          stl, ready, done, tk;
    logic [31:0] din;
    bit          ireq, dreq, dwe, alu, chk_alu, rfw, pcw, chk_wb, trp;
    logic [1:0]  wbs, pcs;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] m_cnt;
  logic [31:0] m_ir;

  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [6:0] opcode_of(input int k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_LUI:   return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      default: return 7'b1111111;
    endcase
  endfunction

  // One expected cycle of phase ph; fin marks the cycle where the phase completes.
  task automatic push(input state_t ph, input int k, input logic [4:0] rd, input bit stl,
                      input bit fin, input bit taken, input logic [31:0] instr);
    cyc_t c;
    c.st = ph; c.stl = stl;
    c.ready = 1'($urandom_range(0, 1)); c.done = 1'($urandom_range(0, 1));
    c.tk = 1'($urandom_range(0, 1)); c.din = $urandom;
    c.ireq = 0; c.dreq = 0; c.dwe = 0; c.alu = 0; c.chk_alu = 0;
    c.rfw = 0; c.pcw = 0; c.chk_wb = 0; c.trp = 0; c.wbs = 2'd0; c.pcs = 2'd0;
    case (ph)
      st_fetch: begin
        c.ireq = 1;
        if (!stl) begin
          c.ready = fin;
          if (fin) c.din = instr;
        end
      end
      st_execute: begin
        c.chk_alu = 1;
        c.alu = (k == K_AUIPC) || (k == K_JAL) || (k == K_BR);
        c.tk = taken;
        if (k == K_BR && !stl) begin
          c.pcw = 1;
          c.pcs = taken ? 2'd1 : 2'd0;
        end
      end
      st_mem: begin
        c.dreq = 1;
        c.dwe = (k == K_ST);
        if (!stl) begin
          c.done = fin;
          if (fin && k == K_ST) begin c.pcw = 1; c.pcs = 2'd0; end
        end
      end
      st_writeback: begin
        if (!stl) begin
          c.rfw = (rd != 5'd0) && (k != K_ILL);
          c.pcw = 1;
          c.pcs = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
          c.chk_wb = 1;
          c.wbs = (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
        end
      end
      st_trap: c.trp = 1;
      default: ;
    endcase
    q.push_back(c);
  endtask

  task automatic build(input logic [31:0] instr, input int fw, input int mw, input bit taken,
                       input int st_ph, input int st_len);
    int     k;
    state_t ph[$];
    int     n;
    k = classify(instr[6:0]);
    ph.push_back(st_fetch);
    ph.push_back(st_decode);
`ifdef ILLEGAL_TRAP_EN
    if (k == K_ILL) begin
      repeat (4) ph.push_back(st_trap);
    end else begin
`else
    begin
`endif
      ph.push_back(st_execute);
      if (k == K_LD) begin ph.push_back(st_mem); ph.push_back(st_writeback); end
      else if (k == K_ST) ph.push_back(st_mem);
      else if (k != K_BR) ph.push_back(st_writeback);
    end
    for (int p = 0; p < ph.size(); p++) begin
      if (p == st_ph) repeat (st_len) push(ph[p], k, instr[11:7], 1'b1, 1'b0, taken, instr);
      n = (ph[p] == st_fetch) ? fw : (ph[p] == st_mem) ? mw : 0;
      repeat (n) push(ph[p], k, instr[11:7], 1'b0, 1'b0, taken, instr);
      push(ph[p], k, instr[11:7], 1'b0, 1'b1, taken, instr);
    end
  endtask

  task automatic play(input int lim);
    cyc_t c;
    int   n;
    n = 0;
    while (q.size() > 0 && n < lim) begin
      c = q.pop_front();
      imem_ready = c.ready; dmem_done = c.done; stall = c.stl;
      branch_taken = c.tk; instr_in = c.din;
      #1;
      check_val("state", 32'(state_o), 32'(c.st));
      check_val("imem_req", 32'(imem_req), 32'(c.ireq));
      check_val("dmem_req", 32'(dmem_req), 32'(c.dreq));
      check_val("rf_we", 32'(rf_we), 32'(c.rfw));
      check_val("pc_we", 32'(pc_we), 32'(c.pcw));
      check_val("trap", 32'(trap), 32'(c.trp));
      check_val("ir", ir, m_ir);
      check_val("retire_cnt", retire_cnt, m_cnt);
      if (c.dreq) check_val("dmem_we", 32'(dmem_we), 32'(c.dwe));
      if (c.chk_alu) check_val("alu_src_pc", 32'(alu_src_pc), 32'(c.alu));
      if (c.chk_wb) check_val("wb_sel", 32'(wb_sel), 32'(c.wbs));
      if (c.pcw) check_val("pc_sel", 32'(pc_sel), 32'(c.pcs));
      @(negedge clk);
      if (c.pcw) m_cnt = m_cnt + 32'd1;
      if (c.st == st_fetch && !c.stl && c.ready) m_ir = c.din;
      n++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ready = 1'b1; dmem_done = 1'b1; stall = 1'b0;
    #1;
    check_val("rst_imem_req", 32'(imem_req), 32'd0);
    check_val("rst_dmem_req", 32'(dmem_req), 32'd0);
    check_val("rst_strobes", {28'd0, dmem_we, rf_we, pc_we, alu_src_pc}, 32'd0);
    check_val("rst_trap", 32'(trap), 32'd0);
    check_val("rst_sels", {28'd0, wb_sel, pc_sel}, 32'd0);
    @(negedge clk);
    reset = 1'b0; imem_ready = 1'b0; dmem_done = 1'b0;
    m_cnt = 32'd0; m_ir = RST_IR;
    #1;
    check_val("rst_state", 32'(state_o), 32'(st_fetch));
    check_val("rst_ir", ir, RST_IR);
    check_val("rst_retire", retire_cnt, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int          k;
    @(negedge clk);
    do_reset();

    // LUI x1 with immediate fetch acceptance
    build(32'h123450B7, 0, 0, 1'b0, -1, 0);
    play(100);
    check_val("lui_ir", ir, 32'h123450B7);
    check_val("lui_retire", retire_cnt, 32'd1);

    // LOAD with three wait cycles on dmem_done
    build(32'h00012083, 0, 3, 1'b0, -1, 0);
    play(100);

    // BEQ taken then not taken
    build(32'h00208463, 0, 0, 1'b1, -1, 0);
    play(100);
    build(32'h00208463, 0, 0, 1'b0, -1, 0);
    play(100);

    // AUIPC x5 stalled two cycles in writeback
    build(32'h00001297, 0, 0, 1'b0, 3, 2);
    play(100);

    // Illegal opcode 1111111
    build(32'h0000007F, 1, 0, 1'b0, -1, 0);
    play(100);
`ifdef ILLEGAL_TRAP_EN
    check_val("trap_retire", retire_cnt, m_cnt);
    do_reset();
`endif

    // Store interrupted by reset in its second MEM cycle
    build(32'h00112223, 0, 3, 1'b0, -1, 0);
    play(5);
    do_reset();

    // Counter wrap
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    m_cnt = 32'hFFFF_FFFF;
    check_val("wrap_pre", retire_cnt, m_cnt);
    build(32'h00500093, 0, 0, 1'b0, -1, 0);
    play(100);
    check_val("wrap_post", retire_cnt, 32'd0);

    // Random instruction stream
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
`ifdef ILLEGAL_TRAP_EN
      if (k == K_ILL) k = K_R;
`endif
      w = $urandom;
      if (k == K_ILL) begin
        while (classify(w[6:0]) != K_ILL) w = $urandom;
      end else begin
        w[6:0] = opcode_of(k);
      end
      if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
      build(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
            $urandom_range(0, 6), $urandom_range(1, 2));
      play(100);
    end
    check_val("final_retire", retire_cnt, m_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
